// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage RISC-V core.
// Generates the stall, flush and forwarding controls for the pipe.
// Three hazards are handled: load-use (one bubble), taken branch (flush the wrong path)
// and data-memory busy (freeze the whole pipe). Performance counters track stall and flush cycles.
module pipe_hazard_ctrl #(
  parameter logic [1:0] LOAD_SEL = 2'b01,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       ex_wR,
  input  logic             ex_rf_we,
  input  logic [1:0]       ex_wd_sel,
  input  logic [4:0]       mem_wR,
  input  logic             mem_rf_we,
  input  logic [4:0]       wb_wR,
  input  logic             wb_rf_we,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    BUBBLE = 2'b01,
    WAIT   = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       ex_rs1_q, ex_rs2_q;
  logic             ex_re1_q, ex_re2_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lu_haz;

  // Forward select for one EX operand; MEM result is younger so it wins over WB, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic re, input logic [4:0] rs,
                                         input logic m_we, input logic [4:0] m_wr,
                                         input logic w_we, input logic [4:0] w_wr);
    logic [1:0] sel;
    sel = 2'b00;
    if (re && m_we && (m_wr != 5'd0) && (m_wr == rs))
      sel = 2'b01;
    else if (re && w_we && (w_wr != 5'd0) && (w_wr == rs))
      sel = 2'b10;
    return sel;
  endfunction

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    lu_haz = ex_rf_we && (ex_wd_sel == LOAD_SEL) && (ex_wR != 5'd0) &&
             ((id_re1 && (id_rs1 == ex_wR)) || (id_re2 && (id_rs2 == ex_wR)));
  end

  // Stall/flush decode with priority mem_busy > ex_br_taken > lu_haz.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (mem_busy) begin
      // Branch stays pending while EX is frozen; it resolves once busy drops.
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
    end else if (ex_br_taken) begin
      // Anything hazarding in ID is wrong-path and gets flushed anyway.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_haz) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  // Operand forwarding from the registered EX sources.
  always_comb begin
    forward_a = fwd_sel(ex_re1_q, ex_rs1_q, mem_rf_we, mem_wR, wb_rf_we, wb_wR);
    forward_b = fwd_sel(ex_re2_q, ex_rs2_q, mem_rf_we, mem_wR, wb_rf_we, wb_wR);
  end

  // Shadow of the ID/EX source fields, following the ID/EX latch hold/flush behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs1_q <= 5'd0;
      ex_rs2_q <= 5'd0;
      ex_re1_q <= 1'b0;
      ex_re2_q <= 1'b0;
    end else if (idex_stall) begin
      ex_rs1_q <= ex_rs1_q;
      ex_rs2_q <= ex_rs2_q;
      ex_re1_q <= ex_re1_q;
      ex_re2_q <= ex_re2_q;
    end else if (idex_flush) begin
      ex_rs1_q <= 5'd0;
      ex_rs2_q <= 5'd0;
      ex_re1_q <= 1'b0;
      ex_re2_q <= 1'b0;
    end else begin
      ex_rs1_q <= id_rs1;
      ex_rs2_q <= id_rs2;
      ex_re1_q <= id_re1;
      ex_re2_q <= id_re2;
    end
  end

  // Controller state next-state logic.
  always_comb begin
    state_d = state_q;
    if (mem_busy) begin
      state_d = WAIT;
    end else begin
      case (state_q)
        RUN:     state_d = (lu_haz && !ex_br_taken) ? BUBBLE : RUN;
        BUBBLE:  state_d = RUN;
        WAIT:    state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Stall and flush performance counters, wrapping on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall || exmem_stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ifid_flush)              flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign ctrl_state = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

  // The load has moved past EX by the time the bubble sits there.
  a_bubble_no_luhaz: assert property (@(posedge clk) disable iff (rst)
    (state_q == BUBBLE) |-> !lu_haz);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_wR, mem_wR, wb_wR;
  logic        id_re1, id_re2, ex_rf_we, mem_rf_we, wb_rf_we, ex_br_taken, mem_busy;
  logic [1:0]  ex_wd_sel;
  logic        pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush;
  logic [1:0]  forward_a, forward_b, ctrl_state;
  logic [31:0] stall_cnt, flush_cnt;
  logic [5:0]  ctl;

  int total = 0;
  int bad   = 0;

  assign ctl = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LOAD_SEL(2'b01), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_wd_sel(ex_wd_sel),
    .mem_wR(mem_wR), .mem_rf_we(mem_rf_we),
    .wb_wR(wb_wR), .wb_rf_we(wb_rf_we),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .forward_a(forward_a), .forward_b(forward_b), .ctrl_state(ctrl_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_re1 = 0; id_re2 = 0;
    ex_wR = 0; ex_rf_we = 0; ex_wd_sel = 2'b00;
    mem_wR = 0; mem_rf_we = 0; wb_wR = 0; wb_rf_we = 0;
    ex_br_taken = 0; mem_busy = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    total++; if (ctl !== 6'b0) begin bad++; $display("FAIL rst_ctl got=%b exp=%b", ctl, 6'b0); end
    total++; if ({forward_a, forward_b} !== 4'b0) begin bad++; $display("FAIL rst_fwd got=%b exp=0000", {forward_a, forward_b}); end
    total++; if (ctrl_state !== 2'b00) begin bad++; $display("FAIL rst_state got=%b exp=00", ctrl_state); end
    total++; if (stall_cnt !== 0 || flush_cnt !== 0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    // lw x5 in EX, add x6,x5,x7 in ID
    ex_wR = 5; ex_rf_we = 1; ex_wd_sel = 2'b01;
    id_rs1 = 5; id_re1 = 1; id_rs2 = 7; id_re2 = 1; #1;
    total++; if (ctl !== 6'b110001) begin bad++; $display("FAIL lu_ctl got=%b exp=110001", ctl); end
    total++; if (ctrl_state !== 2'b00) begin bad++; $display("FAIL lu_state0 got=%b exp=00", ctrl_state); end
    step();
    // bubble in EX, load in MEM, add still in ID
    ex_wR = 0; ex_rf_we = 0; ex_wd_sel = 2'b00; mem_wR = 5; mem_rf_we = 1; #1;
    total++; if (ctrl_state !== 2'b01) begin bad++; $display("FAIL lu_bubble got=%b exp=01", ctrl_state); end
    total++; if (ctl !== 6'b0) begin bad++; $display("FAIL lu_ctl2 got=%b exp=000000", ctl); end
    total++; if (forward_a !== 2'b00) begin bad++; $display("FAIL lu_fwd_bubble got=%b exp=00", forward_a); end
    total++; if (stall_cnt !== 1) begin bad++; $display("FAIL lu_stallcnt got=%0d exp=1", stall_cnt); end
    step();
    // add in EX, load in WB
    mem_wR = 0; mem_rf_we = 0; wb_wR = 5; wb_rf_we = 1; id_re1 = 0; id_re2 = 0; #1;
    total++; if (forward_a !== 2'b10) begin bad++; $display("FAIL lu_fwd_a got=%b exp=10", forward_a); end
    total++; if (forward_b !== 2'b00) begin bad++; $display("FAIL lu_fwd_b got=%b exp=00", forward_b); end
    total++; if (ctrl_state !== 2'b00) begin bad++; $display("FAIL lu_state2 got=%b exp=00", ctrl_state); end
    total++; if (stall_cnt !== 1) begin bad++; $display("FAIL lu_stallcnt2 got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // add x3 in EX (ALU result), sub x4,x3,x3 in ID
    ex_wR = 3; ex_rf_we = 1; ex_wd_sel = 2'b00;
    id_rs1 = 3; id_rs2 = 3; id_re1 = 1; id_re2 = 1; #1;
    total++; if (ctl !== 6'b0) begin bad++; $display("FAIL b2b_ctl got=%b exp=000000", ctl); end
    step();
    idle(); mem_wR = 3; mem_rf_we = 1; #1;
    total++; if ({forward_a, forward_b} !== 4'b0101) begin bad++; $display("FAIL b2b_fwd got=%b exp=0101", {forward_a, forward_b}); end
    total++; if (ctl !== 6'b0) begin bad++; $display("FAIL b2b_ctl2 got=%b exp=000000", ctl); end
  endtask

  task automatic test_fwd_priority();
    do_reset();
    id_rs1 = 0; id_re1 = 1; id_rs2 = 9; id_re2 = 1;
    step();
    mem_wR = 9; mem_rf_we = 1; wb_wR = 9; wb_rf_we = 1; #1;
    total++; if (forward_b !== 2'b01) begin bad++; $display("FAIL fwd_mem_wins got=%b exp=01", forward_b); end
    total++; if (forward_a !== 2'b00) begin bad++; $display("FAIL fwd_x0_a got=%b exp=00", forward_a); end
    mem_rf_we = 0; #1;
    total++; if (forward_b !== 2'b10) begin bad++; $display("FAIL fwd_wb got=%b exp=10", forward_b); end
    mem_rf_we = 1; mem_wR = 0; #1;
    total++; if (forward_b !== 2'b10) begin bad++; $display("FAIL fwd_memx0 got=%b exp=10", forward_b); end
    id_rs2 = 0;
    step();
    mem_wR = 0; wb_wR = 0; #1;
    total++; if (forward_b !== 2'b00) begin bad++; $display("FAIL fwd_x0_b got=%b exp=00", forward_b); end
  endtask

  task automatic test_branch_over_lu();
    do_reset();
    ex_wR = 5; ex_rf_we = 1; ex_wd_sel = 2'b01;
    id_rs1 = 5; id_re1 = 1; ex_br_taken = 1; #1;
    total++; if (ctl !== 6'b000011) begin bad++; $display("FAIL br_ctl got=%b exp=000011", ctl); end
    step();
    idle(); #1;
    total++; if (flush_cnt !== 1) begin bad++; $display("FAIL br_flushcnt got=%0d exp=1", flush_cnt); end
    total++; if (ctrl_state !== 2'b00) begin bad++; $display("FAIL br_state got=%b exp=00", ctrl_state); end
    total++; if (stall_cnt !== 0) begin bad++; $display("FAIL br_stallcnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_busy_branch();
    do_reset();
    mem_busy = 1; ex_br_taken = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (ctl !== 6'b111100) begin bad++; $display("FAIL busy_ctl c%0d got=%b exp=111100", c, ctl); end
      if (c > 0) begin
        total++; if (ctrl_state !== 2'b10) begin bad++; $display("FAIL busy_state c%0d got=%b exp=10", c, ctrl_state); end
      end
      step();
    end
    mem_busy = 0; #1;
    total++; if (ctl !== 6'b000011) begin bad++; $display("FAIL busy_release got=%b exp=000011", ctl); end
    total++; if (stall_cnt !== 3) begin bad++; $display("FAIL busy_stallcnt got=%0d exp=3", stall_cnt); end
    total++; if (ctrl_state !== 2'b10) begin bad++; $display("FAIL busy_state3 got=%b exp=10", ctrl_state); end
    step();
    ex_br_taken = 0; #1;
    total++; if (flush_cnt !== 1) begin bad++; $display("FAIL busy_flushcnt got=%0d exp=1", flush_cnt); end
    total++; if (ctl !== 6'b0 || ctrl_state !== 2'b00) begin bad++; $display("FAIL busy_after got=%b/%b exp=000000/00", ctl, ctrl_state); end
  endtask

  task automatic test_reset_in_bubble();
    do_reset();
    ex_wR = 5; ex_rf_we = 1; ex_wd_sel = 2'b01; id_rs1 = 5; id_re1 = 1;
    step();
    ex_wR = 0; ex_rf_we = 0; ex_wd_sel = 2'b00; id_rs1 = 4; #1;
    total++; if (ctrl_state !== 2'b01 || stall_cnt !== 1) begin bad++; $display("FAIL rb_pre got=%b/%0d exp=01/1", ctrl_state, stall_cnt); end
    rst = 1;
    step();
    rst = 0; idle(); mem_wR = 4; mem_rf_we = 1; #1;
    total++; if (ctl !== 6'b0 || {forward_a, forward_b} !== 4'b0) begin bad++; $display("FAIL rb_out got=%b/%b exp=000000/0000", ctl, {forward_a, forward_b}); end
    total++; if (ctrl_state !== 2'b00) begin bad++; $display("FAIL rb_state got=%b exp=00", ctrl_state); end
    total++; if (stall_cnt !== 0 || flush_cnt !== 0) begin bad++; $display("FAIL rb_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
  endtask

  initial begin
    rst = 1'b1; idle();
    test_reset();
    test_load_use();
    test_back_to_back();
    test_fwd_priority();
    test_branch_over_lu();
    test_busy_branch();
    test_reset_in_bubble();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
